// File: rtl/div_unit_pkg.sv
// Shared definitions for the RV32M divide/remainder unit: operation and state
// encodings, plus the translation from the ALU's control codes.
package div_unit_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_CALC = 2'b01,
        DS_FIX  = 2'b10,
        DS_DONE = 2'b11
    } div_state_t;

    // alu_control values of the M-extension divide group
    localparam logic [4:0] ALU_DIV  = 5'b10100;
    localparam logic [4:0] ALU_DIVU = 5'b10101;
    localparam logic [4:0] ALU_REM  = 5'b10110;
    localparam logic [4:0] ALU_REMU = 5'b10111;

    function automatic div_op_t alu_to_div_op(input logic [4:0] alu_ctrl);
        div_op_t op;
        case (alu_ctrl)
            ALU_DIV:  op = OP_DIV;
            ALU_DIVU: op = OP_DIVU;
            ALU_REM:  op = OP_REM;
            ALU_REMU: op = OP_REMU;
            default:  op = OP_DIVU;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit
// per cycle, with RISC-V divide-by-zero and signed-overflow results applied.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return (~v) + XLEN'(1);
    endfunction

    function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] v);
        return (v < 0) ? negate(v) : v;
    endfunction

    div_state_t       state_q, state_d;
    div_op_t          op_q, op_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic signed [XLEN-1:0] dividend_s;
    logic signed [XLEN-1:0] divisor_s;
    div_op_t                op_in;
    logic                   in_signed;
    logic                   in_is_div;
    logic [XLEN:0]          shifted;
    logic [XLEN:0]          diff;
    logic                   trial_ok;

    assign dividend_s = dividend_i;
    assign divisor_s  = divisor_i;
    assign op_in      = div_op_t'(op_i);
    assign in_signed  = (op_in == OP_DIV) || (op_in == OP_REM);
    assign in_is_div  = (op_in == OP_DIV) || (op_in == OP_DIVU);

    // A shifted remainder with its top bit set always exceeds the divisor.
    assign shifted  = {rem_q, quo_q[XLEN-1]};
    assign diff     = shifted - {1'b0, dvs_q};
    assign trial_ok = shifted[XLEN] | ~diff[XLEN];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;
        case (state_q)
            DS_IDLE: begin
                if (start_i) begin
                    op_d = op_in;
                    if (divisor_i == '0) begin
                        result_d = in_is_div ? '1 : dividend_i;
                        state_d  = DS_DONE;
                    end else if (in_signed && dividend_i == INT_MIN && divisor_i == '1) begin
                        result_d = in_is_div ? INT_MIN : '0;
                        state_d  = DS_DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = in_signed ? abs_val(dividend_s) : dividend_i;
                        dvs_d   = in_signed ? abs_val(divisor_s) : divisor_i;
                        q_neg_d = in_signed & (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
                        r_neg_d = in_signed & dividend_i[XLEN-1];
                        cnt_d   = '0;
                        state_d = DS_CALC;
                    end
                end
            end
            DS_CALC: begin
                rem_d = trial_ok ? diff[XLEN-1:0] : shifted[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], trial_ok};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    state_d = DS_FIX;
                end
            end
            DS_FIX: begin
                case (op_q)
                    OP_DIV:  result_d = q_neg_q ? negate(quo_q) : quo_q;
                    OP_DIVU: result_d = quo_q;
                    OP_REM:  result_d = r_neg_q ? negate(rem_q) : rem_q;
                    default: result_d = rem_q;
                endcase
                state_d = DS_DONE;
            end
            default: begin
                state_d = DS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= DS_IDLE;
            op_q     <= OP_DIV;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q == DS_CALC) || (state_q == DS_FIX);
    assign valid_o  = (state_q == DS_DONE);
    assign result_o = result_q;

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 restoring divider for the RV32M DIV, DIVU, REM and REMU instructions. It sits directly downstream of the execute-stage `alu`. The ALU decodes a divide/remainder `alu_control`, pulses `start_i`, and holds the CPU stalled while `busy_o` is high. The unit returns a 32-bit quotient or remainder with a one-cycle `valid_o` strobe and applies all RISC-V special-case results.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is verified.
- `clk_i` in, 1: clock. All state updates on the rising edge.
- `rst_n_i` in, 1: reset, asynchronous, active-low.
- `start_i` in, 1: start request. Sampled only in IDLE.
- `op_i` in, 2: `div_op_t` encoding. 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `dividend_i` in, XLEN: rs1. Sampled with `start_i`.
- `divisor_i` in, XLEN: rs2. Sampled with `start_i`.
- `busy_o` out, 1: high in CALC and FIX. The ALU ORs it into `stall_cpu_o`.
- `valid_o` out, 1: result strobe. High only in the DONE state.
- `result_o` out, XLEN: quotient (DIV/DIVU) or remainder (REM/REMU). Held until the next DONE.

## Operation
- States: IDLE, CALC, FIX, DONE (`div_state_t`).
- IDLE:
  - On `start_i` the unit latches `op_i` and the operands.
  - Signed ops store the absolute values. They also record `q_neg = a[31]^b[31]` and `r_neg = a[31]`.
  - The remainder register is cleared, the quotient register is loaded with |dividend|, and the 5-bit counter is set to 0.
- Special cases are detected in IDLE at start and bypass CALC (IDLE→DONE directly):
  - Divisor == 0: quotient = 0xFFFF_FFFF for both DIV and DIVU; remainder = dividend, unmodified.
  - Signed overflow (DIV/REM, dividend 0x8000_0000, divisor 0xFFFF_FFFF): quotient = 0x8000_0000, remainder = 0.
- CALC, one bit per cycle:
  - {rem, quo} shifts left 1.
  - Trial = rem − |divisor|, computed 33 bits wide.
  - If trial is non-negative: rem = trial and quo[0] = 1. Otherwise rem is unchanged and quo[0] = 0.
  - The counter increments. At counter == 31 the state goes to FIX.
- FIX:
  - Negate the quotient if `q_neg` and the op is DIV.
  - Negate the remainder if `r_neg` and the op is REM.
  - Load `result_o` with the selected value, then go to DONE.
- DONE: `valid_o` = 1 for exactly one cycle, then return to IDLE.
- `start_i` outside IDLE is ignored. No queueing, no abort.
- DIVU/REMU never negate. Sign bits are ignored.

## Timing
- Start sampled at edge E0.
- Normal path: CALC during E1..E32, FIX at E33, DONE state after E33.
  - `valid_o` is high in cycle E33..E34, which is 34 cycles after E0.
  - `busy_o` is high after E0 until E33.
- Special-case path: DONE after E0. `valid_o` is high in cycle E0..E1, and `busy_o` never asserts.
- A new `start_i` is accepted on the edge that leaves DONE only if the state is already IDLE. Back-to-back issue therefore costs 35 cycles minimum on the normal path.
- Reset values: state IDLE; `busy_o` 0; `valid_o` 0; `result_o` 0; counter 0; internal registers 0.
- Reset asserted mid-operation:
  - The state machine returns to IDLE immediately (asynchronous) and the in-flight result is discarded.
  - `valid_o` never asserts for that operation.
- Operands and `op_i` may change after E0 without effect.

## Structure
- Shared package (the existing defines header): `div_op_t` enum (DIV, DIVU, REM, REMU) and `div_state_t` enum, plus the mapping from the ALU's `ALU_DIV`/`ALU_DIVU`/`ALU_REM`/`ALU_REMU` codes to `div_op_t`.
- Single module, no sub-modules.
- Contents: the 33-bit subtractor, the quotient/remainder shift registers, the counter, and the sign-fix negators, shared by both.
- The ALU owns the start-pulse generation and stall gating.

## Test plan
- DIVU 5463 / 31 → `result_o` = 176, `valid_o` exactly 34 cycles after start, `busy_o` high for 33 cycles. Repeat as REMU → 7.
- DIV −7 (0xFFFF_FFF9) / 2 → 0xFFFF_FFFD (−3). Repeat as REM → 0xFFFF_FFFF (−1). Repeat as DIVU → 0x7FFF_FFFC.
- Divide by zero:
  - DIV 1234 / 0 → 0xFFFF_FFFF; REMU 1234 / 0 → 1234.
  - Both with `valid_o` one cycle after start and `busy_o` never high.
- Overflow: DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000; REM of the same operands → 0. Both take the 1-cycle path.
- Second `start_i` with new operands issued at cycle 10 of a running op → ignored; the first result is correct and only one `valid_o` pulse occurs.
- `rst_n_i` low at cycle 15 of a DIVU → all outputs 0 immediately, no `valid_o`. A fresh DIVU 100 / 7 afterwards → 14.
